// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative 32x32 shift-add multiplier for mult/multu writing HI/LO
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] result;

  // Magnitude of the most negative value is 2^(W-1), which still fits unsigned.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (is_signed && a[WIDTH-1]) a_mag = ~a + 1'b1;
    if (is_signed && b[WIDTH-1]) b_mag = ~b + 1'b1;
  end

  // One shift-add step: the carry out of the upper-half add becomes the new MSB.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    acc_step = {add_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    result = acc;
    if (neg) result = ~acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - self-checking bench for mult_unit against an arithmetic reference model
module tb_mult_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy counts down WIDTH+1 edges from acceptance, product from plain arithmetic.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [63:0]  m_prod = '0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_hi, m_lo} = m_prod;
        end
      end else if (start) begin
        longint sa, sb;
        longint unsigned ua, ub;
        m_busy = 1'b1;
        m_left = W + 1;
        if (is_signed) begin
          sa = $signed(a);
          sb = $signed(b);
          m_prod = sa * sb;
        end else begin
          ua = a;
          ub = b;
          m_prod = ua * ub;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy_done_excl", busy & done, 1'b0);
  end

  task automatic do_start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
    a = ia; b = ib; is_signed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; n starts at edges already elapsed.
  task automatic wait_done(input int from, output int n);
    n = from;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!done && n < 80);
    if (!done) chk("done_timeout", 64'(n), 64'(W + 1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic s, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    do_start(ia, ib, s);
    wait_done(0, n);
    chk({name, "_latency"}, 64'(n), 64'(W + 1));
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    int extra;
    repeat (3) @(posedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'h0000000F);
    run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op("s_m2x3", 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("s_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1);
    run_op("s_min2", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
    run_op("s_zero", 32'h0, 32'h80000001, 1'b1, 32'h0, 32'h0);
    run_op("s_7xm1", 32'd7, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9);

    // start pulsed mid-operation is ignored
    do_start(32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1 a = 32'd7; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, n);
    chk("ignore_latency", 64'(n), 64'(W + 1));
    chk("ignore_lo", {hi, lo}, 64'd15);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) extra++;
    end
    chk("ignore_no_second_done", 64'(extra), 64'd0);

    // back-to-back: new start accepted in the done cycle
    do_start(32'd3, 32'd5, 1'b0);
    wait_done(0, n);
    chk("b2b_first_lo", {hi, lo}, 64'd15);
    do_start(32'd2, 32'd4, 1'b0);
    n = 0;
    while (!done && n < 80) begin
      chk("b2b_hold", {hi, lo}, 64'd15);
      @(posedge clk);
      n++;
      #1;
    end
    chk("b2b_latency", 64'(n), 64'(W + 1));
    chk("b2b_second", {hi, lo}, 64'd8);

    // asynchronous reset mid-operation
    do_start(32'd3, 32'd5, 1'b0);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) extra++;
    end
    chk("rst_idle_after", 64'(extra), 64'd0);
    run_op("post_rst_6x7", 32'd6, 32'd7, 1'b0, 32'h0, 32'd42);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
